car_nav_ctrl: RTL and testbench

Manoeuvre sequencer for the car-control datapath. It debounces the three obstacle sensors (front, left, right) and runs a Moore FSM that issues exactly one drive command at a time: forward, timed left turn, timed right turn, or timed reverse. It counts failed reverse attempts and parks in a STUCK state when the car cannot escape. It sits between the raw sensor inputs and the motor-command outputs.

---
 rtl/car_nav_ctrl.sv | 140 ++++++++++++++
 tb/tb_car_nav_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_nav_ctrl.sv
// Manoeuvre sequencer: debounces the front/left/right obstacle sensors and runs a Moore FSM
// that issues one drive command at a time (forward, timed turn, timed reverse) or parks stuck.
module car_nav_ctrl #(
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned TURN_CYCLES = 8,
  parameter int unsigned BACK_CYCLES = 6,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       front,
  input  logic       left,
  input  logic       right,
  output logic       go_front,
  output logic       go_left,
  output logic       go_right,
  output logic       go_back,
  output logic       stuck,
  output logic [2:0] state
);

  localparam int unsigned TmrMax = (TURN_CYCLES > BACK_CYCLES) ? TURN_CYCLES : BACK_CYCLES;
  localparam int unsigned DbW    = $clog2(DEBOUNCE + 1);
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam int unsigned RtW    = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDecide = 3'd1,
    StFwd    = 3'd2,
    StTurnL  = 3'd3,
    StTurnR  = 3'd4,
    StBack   = 3'd5,
    StStuck  = 3'd6
  } state_e;

  // Sensor bit order: 0 = front, 1 = left, 2 = right.
  logic [2:0]          raw;
  logic [2:0]          sync1_q, sync2_q, filt_q;
  logic [2:0][DbW-1:0] db_cnt_q;

  assign raw = {right, left, front};

  // Filters reset to "obstacle" so nothing moves until clean inputs have propagated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      filt_q   <= '1;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DEBOUNCE - 1)) begin
          filt_q[i]   <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_e            state_q, state_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [RtW-1:0]    retry_q, retry_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    if (!en) begin
      state_d = StIdle;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        StIdle:   state_d = StDecide;
        StDecide: begin
          if (!filt_q[0]) begin
            state_d = StFwd;
            retry_d = '0;
          end else if (!filt_q[1]) begin
            state_d = StTurnL;
            timer_d = TmrW'(TURN_CYCLES - 1);
          end else if (!filt_q[2]) begin
            state_d = StTurnR;
            timer_d = TmrW'(TURN_CYCLES - 1);
          end else if (retry_q < RtW'(MAX_RETRY)) begin
            state_d = StBack;
            timer_d = TmrW'(BACK_CYCLES - 1);
            retry_d = retry_q + 1'b1;
          end else begin
            state_d = StStuck;
          end
        end
        StFwd: begin
          if (filt_q[0]) state_d = StDecide;
        end
        StTurnL, StTurnR, StBack: begin
          // Timer holds at zero on exit rather than wrapping.
          if (timer_q == '0) state_d = StDecide;
          else               timer_d = timer_q - 1'b1;
        end
        StStuck:  state_d = StStuck;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they always match the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      retry_q  <= '0;
      go_front <= 1'b0;
      go_left  <= 1'b0;
      go_right <= 1'b0;
      go_back  <= 1'b0;
      stuck    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      go_front <= (state_d == StFwd);
      go_left  <= (state_d == StTurnL);
      go_right <= (state_d == StTurnR);
      go_back  <= (state_d == StBack);
      stuck    <= (state_d == StStuck);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_car_nav_ctrl.sv
// Bench for car_nav_ctrl: directed scenarios plus randomized sensors/enable/reset, all checked
// each cycle against a sample-history and manoeuvre-countdown model of the sequencer.
module tb_car_nav_ctrl;

  localparam int D = 4;
  localparam int T = 8;
  localparam int B = 6;
  localparam int R = 3;

  logic       clk, rst_n, en, front, left, right;
  logic       go_front, go_left, go_right, go_back, stuck;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  car_nav_ctrl #(
    .DEBOUNCE   (D),
    .TURN_CYCLES(T),
    .BACK_CYCLES(B),
    .MAX_RETRY  (R)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .front   (front),
    .left    (left),
    .right   (right),
    .go_front(go_front),
    .go_left (go_left),
    .go_right(go_right),
    .go_back (go_back),
    .stuck   (stuck),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: raw sample history per sensor (index 0 = newest), filtered value, manoeuvre state,
  // cycles remaining in the current timed manoeuvre, and reverse attempts since last progress.
  bit mh[3][D+1];
  bit mf[3];
  bit m_raw[3];
  bit all_diff;
  int m_state, m_rem, m_retry;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k <= D; k++) mh[s][k] = 1'b1;
        mf[s] = 1'b1;
      end
      m_state = 0;
      m_rem   = 0;
      m_retry = 0;
    end else begin
      m_raw[0] = front;
      m_raw[1] = left;
      m_raw[2] = right;
      if (!en) begin
        m_state = 0;
        m_rem   = 0;
        m_retry = 0;
      end else begin
        case (m_state)
          0: m_state = 1;
          1: begin
            if (!mf[0]) begin
              m_state = 2;
              m_retry = 0;
            end else if (!mf[1]) begin
              m_state = 3;
              m_rem   = T;
            end else if (!mf[2]) begin
              m_state = 4;
              m_rem   = T;
            end else if (m_retry < R) begin
              m_state = 5;
              m_rem   = B;
              m_retry++;
            end else begin
              m_state = 6;
            end
          end
          2: if (mf[0]) m_state = 1;
          3, 4, 5: begin
            if (m_rem == 1) m_state = 1;
            else m_rem--;
          end
          default: ;
        endcase
      end
      // Filtered value flips once the synchronized value has disagreed for D straight edges;
      // the synchronized value seen at this edge is the raw sample from two edges ago.
      for (int s = 0; s < 3; s++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++) if (mh[s][k] == mf[s]) all_diff = 1'b0;
        if (all_diff) mf[s] = ~mf[s];
        for (int k = D; k >= 1; k--) mh[s][k] = mh[s][k-1];
        mh[s][0] = m_raw[s];
      end
    end
  end

  logic [4:0] exp_go, got_go;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_go = {m_state == 2, m_state == 3, m_state == 4, m_state == 5, m_state == 6};
      got_go = {go_front, go_left, go_right, go_back, stuck};
      vectors++;
      if (state !== 3'(m_state) || got_go !== exp_go) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t: state=%0d go=%b, expected state=%0d go=%b",
                 $time, state, got_go, m_state, exp_go);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_model(input int tgt, input int budget, input string name);
    int n = 0;
    while (m_state != tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (m_state != tgt) begin
      miscompares++;
      $display("FAIL %s: state %0d after %0d cycles, expected %0d", name, m_state, n, tgt);
    end
  endtask

  initial begin
    int cnt, cnt2;
    logic prev_back;
    rst_n = 1'b1; en = 1'b0; front = 1'b1; left = 1'b1; right = 1'b1;
    @(negedge clk);

    // Clean start with open road: filters still blocked, so one reverse happens first.
    front = 1'b0; left = 1'b0; right = 1'b0; en = 1'b1;
    apply_reset();
    check_lit("reset_state", state, 0);
    check_lit("reset_stuck", stuck, 0);
    @(negedge clk);
    check_lit("s1_decide", state, 1);
    @(negedge clk);
    check_lit("s1_back_first", state, 5);
    check_lit("s1_model_back", m_state, 5);
    repeat (10) @(negedge clk);
    check_lit("s1_fwd", state, 2);
    check_lit("s1_go_front", go_front, 1);

    // Front blocked, left open: one DECIDE then an 8-cycle left turn, then forward again.
    front = 1'b1;
    repeat (7) @(negedge clk);
    check_lit("s2_decide", state, 1);
    @(negedge clk);
    check_lit("s2_turn_l", state, 3);
    front = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (go_left) cnt++;
      @(negedge clk);
    end
    check_lit("s2_left_cycles", cnt, T);
    check_lit("s2_refwd", state, 2);

    // Front and left blocked: repeated right turns; a 3-cycle right glitch is filtered out.
    front = 1'b1; left = 1'b1; right = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 12) right = 1'b1;
      if (i == 15) right = 1'b0;
      if (go_right) cnt++;
      if (go_back) cnt2++;
    end
    check_lit("s3_right_cycles", cnt, 30);
    check_lit("s3_no_back", cnt2, 0);

    // Boxed in: three reverses then STUCK; en low returns to IDLE; re-enable escapes.
    front = 1'b1; left = 1'b1; right = 1'b1; en = 1'b1;
    apply_reset();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (go_back) cnt++;
    end
    check_lit("s4_back_cycles", cnt, 3 * B);
    check_lit("s4_stuck_state", state, 6);
    check_lit("s4_stuck_flag", stuck, 1);
    check_lit("s4_model_stuck", m_state, 6);
    en = 1'b0;
    @(negedge clk);
    check_lit("s4_idle", state, 0);
    front = 1'b0; en = 1'b1;
    wait_model(2, 30, "s4_escape");
    check_lit("s4_go_front", go_front, 1);

    // Reset on the 4th cycle of a left turn drops go_left without a clock edge.
    front = 1'b1; left = 1'b0; right = 1'b1;
    repeat (11) @(negedge clk);
    check_lit("s5_turn_l", state, 3);
    check_lit("s5_go_left", go_left, 1);
    #2 rst_n = 1'b0;
    #1;
    check_lit("s5_async_go_left", go_left, 0);
    check_lit("s5_async_state", state, 0);
    front = 1'b0; left = 1'b0; right = 1'b0; en = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (go_front | go_left | go_right | go_back) cnt++;
    end
    check_lit("s5_quiet_after_reset", cnt, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    check_lit("s5_restart_fwd", state, 2);

    // en drops on the last reverse cycle: IDLE wins, and the retry budget starts over.
    front = 1'b1; left = 1'b1; right = 1'b1; en = 1'b1;
    apply_reset();
    repeat (7) @(negedge clk);
    check_lit("s6_last_back", state, 5);
    en = 1'b0;
    @(negedge clk);
    check_lit("s6_idle_wins", state, 0);
    en = 1'b1;
    cnt = 0; prev_back = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (go_back && !prev_back) cnt++;
      prev_back = go_back;
    end
    check_lit("s6_retry_restart", cnt, R);
    check_lit("s6_stuck", stuck, 1);

    // Randomized run, sensors biased toward obstacles, occasional en drops and resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) front = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) left  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) right = ($urandom_range(0, 2) != 0);
      if (i % 500 == 250) begin
        front = 1'b1; left = 1'b1; right = 1'b1;
      end
      if (en) begin
        if ($urandom_range(0, 149) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

endmodule
